// File: rtl/serial_shifter_if.sv
// Command/result bundle for the bit-serial shift/rotate engine.
// The controller drives the command fields; the engine returns status and held results.
interface serial_shifter_if;
    logic       start;
    logic [7:0] data;
    logic [2:0] bitcount;
    logic       dir;
    logic       sh_roBar;
    logic       busy;
    logic       done;
    logic [7:0] out;
    logic       c;
    logic       z;

    modport master (
        output start, data, bitcount, dir, sh_roBar,
        input  busy, done, out, c, z
    );

    modport slave (
        input  start, data, bitcount, dir, sh_roBar,
        output busy, done, out, c, z
    );
endinterface

// File: rtl/serial_shifter.sv
// Bit-serial 8-bit shift/rotate engine: one bit position per clock, start/done handshake,
// result/carry/zero held between commands.
module serial_shifter (
    input  logic              clk,
    input  logic              rst,
    serial_shifter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state, state_d;
    logic [7:0] work, work_d;
    logic [2:0] cnt, cnt_d;
    logic       cw, cw_d;
    logic       dir_q, dir_d;
    logic       sh_q, sh_d;
    logic       res_we;
    logic [7:0] out_q;
    logic       c_q;
    logic       z_q;
    logic       fill;

    always_comb begin
        state_d = state;
        work_d  = work;
        cnt_d   = cnt;
        cw_d    = cw;
        dir_d   = dir_q;
        sh_d    = sh_q;
        res_we  = 1'b0;
        fill    = 1'b0;

        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    work_d = bus.data;
                    cnt_d  = bus.bitcount;
                    cw_d   = 1'b0;
                    dir_d  = bus.dir;
                    sh_d   = bus.sh_roBar;
                    if (bus.bitcount == 3'd0) begin
                        state_d = DONE;
                        res_we  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (dir_q) begin
                    fill   = sh_q ? 1'b0 : work[0];
                    cw_d   = work[0];
                    work_d = {fill, work[7:1]};
                end else begin
                    fill   = sh_q ? 1'b0 : work[7];
                    cw_d   = work[7];
                    work_d = {work[6:0], fill};
                end
                cnt_d = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_d = DONE;
                    res_we  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Results are captured on the edge entering DONE so they are visible with the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            cw    <= 1'b0;
            dir_q <= 1'b0;
            sh_q  <= 1'b0;
            out_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b1;
        end else begin
            state <= state_d;
            work  <= work_d;
            cnt   <= cnt_d;
            cw    <= cw_d;
            dir_q <= dir_d;
            sh_q  <= sh_d;
            if (res_we) begin
                out_q <= work_d;
                c_q   <= cw_d;
                z_q   <= (work_d == 8'h00);
            end
        end
    end

    always_comb begin
        bus.busy = (state == SHIFT);
        bus.done = (state == DONE);
        bus.out  = out_q;
        bus.c    = c_q;
        bus.z    = z_q;
    end
endmodule

// File: tb/tb_serial_shifter.sv
// Scoreboard bench for serial_shifter: expected results are queued at start and
// compared (values and arrival cycle) whenever done pulses.
module tb_serial_shifter;
    logic clk = 1'b0;
    logic rst;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    typedef struct {
        logic [7:0]  out;
        logic        c;
        logic        z;
        int unsigned cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;

    serial_shifter_if bus ();

    serial_shifter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    endtask

    // Reference in closed form, as the combinational barrel shifter computes it.
    function automatic logic [9:0] model(input logic [7:0] d, input logic [2:0] n,
                                         input logic dr, input logic sh);
        logic [15:0] dd;
        logic [7:0]  r;
        logic        cc;
        int          ni;
        ni = int'(n);
        dd = {d, d};
        if (dr) r = sh ? (d >> ni) : 8'(dd >> ni);
        else    r = sh ? 8'(d << ni) : dd[15 - ni -: 8];
        if (ni == 0) cc = 1'b0;
        else if (dr) cc = d[ni - 1];
        else         cc = d[8 - ni];
        return {(r == 8'h00), cc, r};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("out", bus.out, e.out);
                check("c", bus.c, e.c);
                check("z", bus.z, e.z);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Caller is aligned just after a rising edge; start is sampled at the next edge.
    task automatic drive_start(input logic [7:0] d, input logic [2:0] n, input logic dr,
                               input logic sh, input bit expect_it);
        logic [9:0] m;
        bus.data     = d;
        bus.bitcount = n;
        bus.dir      = dr;
        bus.sh_roBar = sh;
        bus.start    = 1'b1;
        if (expect_it) begin
            m = model(d, n, dr, sh);
            q.push_back('{m[7:0], m[8], m[9], cyc + int'(n) + 1});
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic [2:0] n;
        logic       dr;
        logic       sh;
    } cmd_t;

    cmd_t plan[8] = '{
        '{8'hAF, 3'd1, 1'b1, 1'b1}, '{8'hAF, 3'd2, 1'b1, 1'b1},
        '{8'hAF, 3'd2, 1'b1, 1'b0}, '{8'hAF, 3'd2, 1'b0, 1'b0},
        '{8'hAF, 3'd1, 1'b0, 1'b1}, '{8'hAF, 3'd2, 1'b0, 1'b1},
        '{8'h01, 3'd1, 1'b1, 1'b1}, '{8'h80, 3'd0, 1'b1, 1'b1}
    };

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.data     = '0;
        bus.bitcount = '0;
        bus.dir      = 1'b0;
        bus.sh_roBar = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_out", bus.out, 8'h00);
        check("rst_c", bus.c, 0);
        check("rst_z", bus.z, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (plan[i]) begin
            drive_start(plan[i].d, plan[i].n, plan[i].dr, plan[i].sh, 1'b1);
            drain();
        end

        // Long command with an ignored start pulse mid-flight.
        drive_start(8'h80, 3'd7, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("busy_long", bus.busy, 1);
            if (i == 2) begin
                bus.start    = 1'b1;
                bus.data     = 8'h55;
                bus.bitcount = 3'd1;
                bus.dir      = 1'b0;
            end
            if (i == 3) bus.start = 1'b0;
        end
        @(negedge clk);
        check("busy_after", bus.busy, 0);
        drain();

        // Back-to-back: second start issued in the first command's DONE cycle.
        drive_start(8'h3C, 3'd3, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        drive_start(8'hA5, 3'd4, 1'b1, 1'b1, 1'b1);
        drain();

        for (int i = 0; i < 16; i++) begin
            drive_start(8'($urandom), 3'($urandom_range(7, 0)), 1'($urandom),
                        1'($urandom), 1'b1);
            if (i % 4 == 3) begin
                repeat (int'(bus.bitcount)) @(posedge clk);
                #1;
                drive_start(8'($urandom), 3'($urandom_range(7, 0)), 1'($urandom),
                            1'($urandom), 1'b1);
            end
            drain();
        end

        // Reset mid-command: result of the preceding command must be cleared, no done.
        drive_start(8'hAF, 3'd1, 1'b1, 1'b1, 1'b1);
        drain();
        drive_start(8'hFF, 3'd5, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_out", bus.out, 8'h00);
        check("abort_c", bus.c, 0);
        check("abort_z", bus.z, 1);
        repeat (10) @(posedge clk);

        check("leftover", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
